// File: rtl/caesar_stream_arb.sv
// caesar_stream_arb: round-robin arbiter sharing one Caesar shift datapath between two character streams.
// Define CAESAR_ARB_STATS_EN to add saturating per-requester and letter counters with a synchronous clear.
module caesar_stream_arb #(
    parameter logic [4:0] KEY0_RST = 5'd3,
    parameter logic [4:0] KEY1_RST = 5'd3,
    parameter int         STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid0,
    input  logic [7:0]        req_data0,
    input  logic              req_dec0,
    output logic              req_ready0,
    input  logic              req_valid1,
    input  logic [7:0]        req_data1,
    input  logic              req_dec1,
    output logic              req_ready1,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [4:0]        cfg_key,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_id,
    input  logic              out_ready
`ifdef CAESAR_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1,
    output logic [STAT_W-1:0] stat_shifted
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic last, can_accept, gnt0, gnt1, accept, sel, dec_in;
    logic [4:0] key0, key1, key_in;
    logic [7:0] data_in, shifted;

    function automatic logic is_alpha(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a);
    endfunction

    // Offset arithmetic stays below 52, so one conditional subtract replaces a modulo.
    function automatic logic [7:0] shift(input logic [7:0] c, input logic [4:0] key, input logic dec);
        logic [7:0] k, base, off;
        k    = {3'd0, key} >= 8'd26 ? {3'd0, key} - 8'd26 : {3'd0, key};
        k    = dec && k != 8'd0 ? 8'd26 - k : k;
        base = c >= 8'h61 ? 8'h61 : 8'h41;
        off  = c - base + k;
        off  = off >= 8'd26 ? off - 8'd26 : off;
        return is_alpha(c) ? base + off : c;
    endfunction

    assign out_valid  = state == FULL;
    assign can_accept = state == EMPTY || out_ready;
    assign gnt0       = req_valid0 && (!req_valid1 || last);
    assign gnt1       = req_valid1 && (!req_valid0 || !last);
    assign req_ready0 = rst_n && can_accept && gnt0;
    assign req_ready1 = rst_n && can_accept && gnt1;
    assign accept     = req_ready0 || req_ready1;
    assign sel        = req_ready1;
    assign data_in    = sel ? req_data1 : req_data0;
    assign key_in     = sel ? key1 : key0;
    assign dec_in     = sel ? req_dec1 : req_dec0;
    assign shifted    = shift(data_in, key_in, dec_in);

    always_comb begin
        state_nx = accept ? FULL : (out_ready ? EMPTY : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= 8'h00;
            out_id   <= 1'b0;
            last     <= 1'b1;
            key0     <= KEY0_RST;
            key1     <= KEY1_RST;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_data <= shifted;
                out_id   <= sel;
                last     <= sel;
            end
            if (cfg_we && cfg_sel) key1 <= cfg_key;
            if (cfg_we && !cfg_sel) key0 <= cfg_key;
        end
    end

`ifdef CAESAR_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt0    <= '0;
            stat_cnt1    <= '0;
            stat_shifted <= '0;
        end else if (stat_clr) begin
            stat_cnt0    <= '0;
            stat_cnt1    <= '0;
            stat_shifted <= '0;
        end else begin
            if (req_ready0 && stat_cnt0 != '1) stat_cnt0 <= stat_cnt0 + STAT_W'(1);
            if (req_ready1 && stat_cnt1 != '1) stat_cnt1 <= stat_cnt1 + STAT_W'(1);
            if (accept && is_alpha(data_in) && stat_shifted != '1) stat_shifted <= stat_shifted + STAT_W'(1);
        end
    end
`endif
endmodule

// File: doc/caesar_stream_arb.md
Name: caesar_stream_arb

Overview:
- Two-requester streaming controller that shares a single Caesar shift datapath between two character sources.
- Holds a per-requester key register and arbitrates round-robin between the requesters.
- Applies the encrypt or decrypt shift to one accepted character per cycle and presents the result through a registered valid/ready output with a source ID.
- Sits between character producers (UART/text buffers) and downstream consumers.

Parameters:
KEY0_RST  3   reset value of requester-0 key register (0..31)
KEY1_RST  3   reset value of requester-1 key register (0..31)
STAT_W    16  width of optional statistics counters

Ports:
clk         in   1  clock, all logic rising-edge
rst_n       in   1  asynchronous active-low reset
req_valid0  in   1  requester 0 has a character
req_data0   in   8  requester 0 ASCII character
req_dec0    in   1  1 = decrypt, 0 = encrypt (requester 0)
req_ready0  out  1  requester 0 character accepted this cycle when high with req_valid0
req_valid1  in   1  requester 1 has a character
req_data1   in   8  requester 1 ASCII character
req_dec1    in   1  1 = decrypt, 0 = encrypt (requester 1)
req_ready1  out  1  requester 1 handshake
cfg_we      in   1  key write strobe
cfg_sel     in   1  key register select (0/1)
cfg_key     in   5  key value written
out_valid   out  1  result register holds a character
out_data    out  8  shifted character
out_id      out  1  requester that produced out_data
out_ready   in   1  consumer accepts when high with out_valid

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid=0, out_data=8'h00, out_id=0.
  - key0=KEY0_RST, key1=KEY1_RST.
  - Round-robin pointer last=1, so requester 0 wins first.
  - req_ready0/1=0 while rst_n low.
- FSM, two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - can_accept = EMPTY | (FULL & out_ready), i.e. a full pipeline with a single output register and no bubble on a continuous stream.
- Grant, combinational:
  - Only one valid: that one is granted.
  - Both valid: grant = ~last.
  - req_readyN = can_accept & grant==N & req_validN; at most one req_ready high per cycle.
- Accept (req_validN & req_readyN):
  - Next edge loads out_data=shift(req_dataN, keyN, req_decN), out_id=N, last=N.
  - FSM goes to or stays in FULL.
  - Latency is 1 cycle from accept to out_valid.
- FULL & out_ready with no accept: next state EMPTY, out_valid=0.
- FULL & !out_ready:
  - out_data and out_id are held stable.
  - Both req_ready are 0.
  - Pending requests wait with no loss and no reordering within a requester.
- Shift rule:
  - k = key mod 26 (26..31 map to 0..5).
  - Decrypt uses (26-k) mod 26.
  - 'a'..'z' rotate within lowercase; 'A'..'Z' rotate within uppercase.
  - Every other byte passes unchanged.
  - Wrap: 'z'+3 gives 'c'; 'a'-3 gives 'x'.
- Key config:
  - cfg_we writes cfg_key into key[cfg_sel] at the edge.
  - The key is sampled at accept. A write in the same cycle as an accept uses the old key, and the new key applies from the next accept.
  - Changing the key never alters out_data already registered.
- Reset mid-operation: the held output is discarded and any in-flight character is lost. After release, the block behaves as from power-up, and keys return to their reset values.
- Inputs are ignored unless the matching valid is high.

Optional Feature:
CAESAR_ARB_STATS_EN
- Defined:
  - Adds outputs stat_cnt0 and stat_cnt1 (STAT_W each), counting accepted characters per requester, and stat_shifted (STAT_W), counting accepted letters, i.e. characters actually rotated.
  - All counters saturate at all-ones and reset to 0.
  - Adds input stat_clr, a synchronous clear of all three counters.
  - If stat_clr and an accept occur in the same cycle, the counters end at 0.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Basic encrypt: reset, key0=3; requester 0 streams "hello world2" with out_ready=1 -> out "khoor zruog2" one char per cycle, out_id=0, first out_valid 1 cycle after first accept; ' ' and '2' pass unchanged.
- Wrap and decrypt:
  - key1=3, req_dec1=0: 'z' -> 'c', 'Z' -> 'C'.
  - req_dec1=1: 'a' -> 'x', 'W' -> 'T'.
  - cfg_key=29 gives the same results as key 3.
- Arbitration:
  - Both valid continuously with data0='a', data1='b', keys 1 and 2 -> outputs alternate 'b'(id0), 'd'(id1), 'b', 'd', ...; first grant goes to 0 after reset.
  - Only requester 1 valid -> it is granted every cycle.
- Backpressure: out_ready=0 for 5 cycles while FULL -> out_data, out_id stable and req_ready0/1=0 throughout; on out_ready=1, the waiting char is accepted in the same cycle with no bubble.
- Key race: cfg_we on the same cycle as accept of 'a', changing key0 from 1 to 4 -> output 'b'; next 'a' -> 'e'.
- Async reset: assert rst_n low mid-stream while FULL -> out_valid=0 immediately (without a clock edge) and keys return to 3; after release, the first grant goes to requester 0.
